// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: RV32I load/store width codes,
// FSM state encoding and requester ids.
`timescale 1ns/1ps
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = F3_LB;
    localparam logic [2:0] F3_SH  = F3_LH;
    localparam logic [2:0] F3_SW  = F3_LW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/dmem_align_check.sv
// Flags accesses that must not reach memory: misaligned halfword/word,
// unknown width codes, and unsigned-width codes used with a store.
`timescale 1ns/1ps
module dmem_align_check
    import dmem_pkg::*;
(
    input  logic       we,
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic       err
);

    always_comb begin
        err = 1'b0;
        case (funct3)
            F3_LB:   err = 1'b0;
            F3_LH:   err = addr_lo[0];
            F3_LW:   err = |addr_lo;
            F3_LBU:  err = we;
            F3_LHU:  err = we | addr_lo[0];
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (cpu, dma) arbiter for the single-port data memory.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed cpu priority.
//
// state  | meaning
// IDLE   | bus idle, grant issued combinationally to the winning requester
// ACCESS | registered command driven onto the memory bus, read data sampled
// RESP   | owner's rvalid/rdata/err presented for one cycle
`timescale 1ns/1ps
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [2:0]            cpu_funct3,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_err,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [2:0]            dma_funct3,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_err,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic                  owner_q, owner_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cpu_rvalid_q, cpu_rvalid_d, cpu_err_q, cpu_err_d;
    logic                  dma_rvalid_q, dma_rvalid_d, dma_err_q, dma_err_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;

    logic                  pick_dma;
    logic                  any_req;
    logic                  grant;
    logic                  access;
    logic                  win_we, win_err;
    logic [2:0]            win_funct3;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [DATA_WIDTH-1:0] resp_data;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    // On a tie the requester that did not win last time goes first.
    assign pick_dma = dma_req && (!cpu_req || (last_q == OWN_CPU));
`else
    assign pick_dma = dma_req && !cpu_req;
`endif

    assign any_req    = cpu_req || dma_req;
    assign grant      = (state_q == IDLE) && any_req && !reset;
    assign cpu_gnt    = grant && !pick_dma;
    assign dma_gnt    = grant && pick_dma;

    assign win_we     = pick_dma ? dma_we     : cpu_we;
    assign win_funct3 = pick_dma ? dma_funct3 : cpu_funct3;
    assign win_addr   = pick_dma ? dma_addr   : cpu_addr;
    assign win_wdata  = pick_dma ? dma_wdata  : cpu_wdata;

    dmem_align_check u_align_check (
        .we      (win_we),
        .funct3  (win_funct3),
        .addr_lo (win_addr[1:0]),
        .err     (win_err)
    );

    // Reset gates the bus combinationally so a write in flight is killed that same cycle.
    assign access      = (state_q == ACCESS) && !reset;
    assign mem_wr_en   = access && we_q && !err_q;
    assign mem_funct3  = access ? funct3_q : 3'b000;
    assign mem_addr    = access ? addr_q   : '0;
    assign mem_wr_data = access ? wdata_q  : '0;

    assign resp_data   = (we_q || err_q) ? '0 : mem_rd_data;

    assign cpu_rvalid  = cpu_rvalid_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_err     = cpu_err_q;
    assign dma_rvalid  = dma_rvalid_q;
    assign dma_rdata   = dma_rdata_q;
    assign dma_err     = dma_err_q;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        err_d        = err_q;
        owner_d      = owner_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rvalid_d = 1'b0;
        cpu_err_d    = 1'b0;
        cpu_rdata_d  = '0;
        dma_rvalid_d = 1'b0;
        dma_err_d    = 1'b0;
        dma_rdata_d  = '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_d       = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = ACCESS;
                    we_d     = win_we;
                    err_d    = win_err;
                    owner_d  = pick_dma ? OWN_DMA : OWN_CPU;
                    funct3_d = win_funct3;
                    addr_d   = win_addr;
                    wdata_d  = win_wdata;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    last_d   = pick_dma ? OWN_DMA : OWN_CPU;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (owner_q == OWN_CPU) begin
                    cpu_rvalid_d = 1'b1;
                    cpu_err_d    = err_q;
                    cpu_rdata_d  = resp_data;
                end else begin
                    dma_rvalid_d = 1'b1;
                    dma_err_d    = err_q;
                    dma_rdata_d  = resp_data;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            owner_q      <= OWN_CPU;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
            dma_err_q    <= 1'b0;
            dma_rdata_q  <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_q       <= OWN_CPU;
`endif
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            err_q        <= err_d;
            owner_q      <= owner_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_err_q    <= cpu_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_err_q    <= dma_err_d;
            dma_rdata_q  <= dma_rdata_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_q       <= last_d;
`endif
        end
    end

endmodule
